bcd_down4: RTL and testbench
============================

BCD_DOWN4 -- requirements
Module: bcd_down4

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, meaning the number of BCD digits in the counter (legal range 1-8).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset that is synchronous and active-low.
REQ-004 The block SHALL have port load, input, 1, a request to load load_val into the counter.
REQ-005 The block SHALL have port load_val, input, 4*DIGITS, the packed BCD load value; digit 0 is in bits [3:0].
REQ-006 The block SHALL have port start, input, 1, a request to begin or resume counting.
REQ-007 The block SHALL have port pause, input, 1, a request to suspend counting.
REQ-008 The block SHALL have port x, input, 1, a count enable: one decrement per cycle while high in RUN.
REQ-009 The block SHALL have port bcd_out, output, 4*DIGITS, the current registered count in packed BCD.
REQ-010 The block SHALL have port busy, output, 1, which is high while the state is RUN or PAUSE.
REQ-011 The block SHALL have port done, output, 1, a registered one-cycle pulse when the count reaches zero.
REQ-012 The block SHALL have port load_err, output, 1, a registered flag indicating that the last load was rejected.

Function
REQ-013 The block SHALL implement a state machine with three states: IDLE, RUN and PAUSE.
REQ-014 Input priority SHALL be, highest first: reset, load, pause, start, x.
REQ-015 Load, any state: if every load_val digit is at most 9, the count SHALL take load_val, the state SHALL go to IDLE, and load_err SHALL go to 0, all on the next edge.
REQ-016 Load with any load_val digit above 9: the count and state SHALL be unchanged and load_err SHALL go to 1.
REQ-017 load_err SHALL hold its value until the next load.
REQ-018 IDLE with start=1 and a nonzero count SHALL go to RUN.
REQ-019 IDLE with start=1 and a zero count SHALL stay in IDLE with no done pulse.
REQ-020 In IDLE, pause and x SHALL be ignored.
REQ-021 RUN with pause=1 SHALL go to PAUSE with no decrement that cycle, regardless of start and x.
REQ-022 PAUSE with start=1 and pause=0 SHALL return to RUN; otherwise the block SHALL stay in PAUSE with the count frozen.
REQ-023 RUN with x=1 SHALL decrement the count by one in BCD:
  - a digit at 0 with a borrow in becomes 9 and propagates the borrow;
  - any other digit decrements and stops the borrow.
REQ-024 RUN with x=0 SHALL hold the count.
REQ-025 Terminal decrement: RUN with x=1 and a count of 1 SHALL, on the same edge:
  - set the count to 0;
  - move the state to IDLE;
  - set done to 1 for exactly one cycle.
REQ-026 The count SHALL never wrap below zero; RUN with a zero count is unreachable.
REQ-027 Latency: every output SHALL reflect its inputs one clock edge after they are sampled; there SHALL be no combinational path from any input to any output.
REQ-028 done SHALL be 0 in every cycle other than the cycle after a terminal decrement.
REQ-029 A load arriving in the same cycle as a terminal decrement SHALL win: the count takes load_val (if valid) and done stays 0.
REQ-030 A valid load during RUN or PAUSE SHALL abort the count and return the block to IDLE.

Reset
REQ-031 When reset=0 at a rising edge, the block SHALL set bcd_out to 0, the state to IDLE, busy to 0, done to 0 and load_err to 0, overriding all other inputs.
REQ-032 Reset SHALL take effect mid-RUN or mid-PAUSE with no done pulse.
REQ-033 Outputs SHALL be undefined only before the first reset edge.

Verification
REQ-034 Bench SHALL check: reset low for 2 cycles with load=1 -> bcd_out=0000, busy=0, done=0, load_err=0.
REQ-035 Bench SHALL check: load 0x0102, start, x=1 continuous -> sequence 0102, 0101, 0100, 0099, 0098, ..., 0001, 0000; done is high exactly in the cycle bcd_out first shows 0000; busy=0 thereafter.
REQ-036 Bench SHALL check: load 0x1000, start, x=1 -> next value 0999 (multi-digit borrow); load 0x0A00 -> load_err=1 and bcd_out still 0999 or later.
REQ-037 Bench SHALL check: in RUN at 0050, pause=1 with start=1 and x=1 -> PAUSE, 0050 held; 5 cycles of x=1 -> still 0050; start -> RUN, decrement resumes.
REQ-038 Bench SHALL check: count 0001 in RUN, x=1 and load 0x0007 in the same cycle -> bcd_out=0007, state IDLE, done=0.
REQ-039 Bench SHALL check: count 0000 in IDLE, start=1 -> busy stays 0 and no done pulse; reset=0 mid-RUN at 0123 -> bcd_out=0000 next edge and no done pulse.

Source files
------------

// File: rtl/bcd_down4.sv
// ---------------------------------------------------------------------------
// bcd_down4 -- loadable packed-BCD down counter with a run/pause controller.
//
// The counter holds DIGITS BCD digits (digit 0 in bits [3:0]). A valid load
// puts the block in IDLE with the new count. start moves IDLE to RUN when the
// count is non-zero. In RUN each cycle with x=1 removes one from the count.
// Reaching zero returns the block to IDLE and pulses done for one cycle.
// pause freezes the count until start resumes it.
//
// Ports
//   clk      : in  1          single clock, rising edge
//   reset    : in  1          synchronous, active-low reset
//   load     : in  1          load request (highest priority after reset)
//   load_val : in  4*DIGITS   packed BCD value to load
//   start    : in  1          begin / resume counting
//   pause    : in  1          suspend counting
//   x        : in  1          count enable while in RUN
//   bcd_out  : out 4*DIGITS   registered count
//   busy     : out 1          registered, high in RUN or PAUSE
//   done     : out 1          registered one-cycle pulse on reaching zero
//   load_err : out 1          registered, last load had a digit above 9
// ---------------------------------------------------------------------------
module bcd_down4 #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  x,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy,
    output logic                  done,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] C_ZERO = {W{1'b0}};
    localparam logic [W-1:0] C_ONE  = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    // True when every digit of v is a legal BCD digit (0..9).
    function automatic logic digits_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    // BCD subtract-one: a zero digit under borrow becomes 9 and passes the
    // borrow on; the first non-zero digit absorbs it.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] res;
        logic         borrow;
        logic [3:0]   d;
        res    = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    res[4*i +: 4] = 4'd9;
                    borrow        = 1'b1;
                end else begin
                    res[4*i +: 4] = d - 4'd1;
                    borrow        = 1'b0;
                end
            end else begin
                res[4*i +: 4] = d;
            end
        end
        return res;
    endfunction

    state_t         r_state;
    logic [W-1:0]   r_count;
    logic           r_busy;
    logic           r_done;
    logic           r_load_err;

    state_t         w_state_nx;
    logic [W-1:0]   w_count_nx;
    logic           w_done_nx;
    logic           w_load_err_nx;

    // Next-state, next-count and next-flag decode; load outranks all control.
    always_comb begin
        w_state_nx    = r_state;
        w_count_nx    = r_count;
        w_done_nx     = 1'b0;
        w_load_err_nx = r_load_err;
        if (load) begin
            // A rejected load leaves count and state exactly as they were.
            if (digits_valid(load_val)) begin
                w_count_nx    = load_val;
                w_state_nx    = S_IDLE;
                w_load_err_nx = 1'b0;
            end else begin
                w_load_err_nx = 1'b1;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (r_count != C_ZERO)) begin
                        w_state_nx = S_RUN;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        w_state_nx = S_PAUSE;
                    end else if (x) begin
                        w_count_nx = bcd_dec(r_count);
                        // Terminal decrement: the count cannot go below zero.
                        if (r_count == C_ONE) begin
                            w_state_nx = S_IDLE;
                            w_done_nx  = 1'b1;
                        end else begin
                            w_state_nx = S_RUN;
                        end
                    end else begin
                        w_state_nx = S_RUN;
                    end
                end
                S_PAUSE: begin
                    if (start && !pause) begin
                        w_state_nx = S_RUN;
                    end else begin
                        w_state_nx = S_PAUSE;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_count    <= C_ZERO;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_count    <= w_count_nx;
            r_busy     <= (w_state_nx != S_IDLE);
            r_done     <= w_done_nx;
            r_load_err <= w_load_err_nx;
        end
    end

    assign bcd_out  = r_count;
    assign busy     = r_busy;
    assign done     = r_done;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_down4.sv
// ---------------------------------------------------------------------------
// tb_bcd_down4 -- directed self-checking bench for bcd_down4 (DIGITS=4).
// An integer-valued model tracks count, mode and flags; a negedge process
// compares every output to it each cycle. Directed literal checks pin down
// specific values along the way.
// ---------------------------------------------------------------------------
module tb_bcd_down4;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] load_val;
    logic        start;
    logic        pause;
    logic        x;
    logic [15:0] bcd_out;
    logic        busy;
    logic        done;
    logic        load_err;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_down4 #(.DIGITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .x        (x),
        .bcd_out  (bcd_out),
        .busy     (busy),
        .done     (done),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    // mode: 0 = idle, 1 = run, 2 = pause
    int   m_val;
    int   m_mode;
    logic m_err;
    logic m_done;
    logic m_ok = 1'b0;

    function automatic logic bcd_ok(input logic [15:0] v);
        logic [15:0] t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            if (t[3:0] > 4'd9) return 1'b0;
            t = t >> 4;
        end
        return 1'b1;
    endfunction

    function automatic int bcd2int(input logic [15:0] v);
        return 1000 * int'(v[15:12]) + 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int          t;
        t = v;
        r = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            r = r | (16'(t % 10) << (4 * i));
            t = t / 10;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_val  <= 0;
            m_mode <= 0;
            m_err  <= 1'b0;
            m_done <= 1'b0;
            m_ok   <= 1'b1;
        end else begin
            m_done <= 1'b0;
            if (load) begin
                if (bcd_ok(load_val)) begin
                    m_val  <= bcd2int(load_val);
                    m_mode <= 0;
                    m_err  <= 1'b0;
                end else begin
                    m_err  <= 1'b1;
                end
            end else if (m_mode == 0) begin
                if (start && m_val > 0) m_mode <= 1;
            end else if (m_mode == 1) begin
                if (pause) begin
                    m_mode <= 2;
                end else if (x) begin
                    m_val <= m_val - 1;
                    if (m_val == 1) begin
                        m_mode <= 0;
                        m_done <= 1'b1;
                    end
                end
            end else begin
                if (start && !pause) m_mode <= 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("model_bcd_out",  32'(bcd_out),  32'(int2bcd(m_val)));
            chk("model_busy",     32'(busy),     32'(m_mode != 0));
            chk("model_done",     32'(done),     32'(m_done));
            chk("model_load_err", 32'(load_err), 32'(m_err));
        end
    end

    // Apply one cycle of inputs; returns #1 after the edge that samples them.
    task automatic drive(input logic r, input logic ld, input logic [15:0] lv,
                         input logic st, input logic pa, input logic xx);
        reset    = r;
        load     = ld;
        load_val = lv;
        start    = st;
        pause    = pa;
        x        = xx;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; load = 1'b1; load_val = 16'h1234;
        start = 1'b0; pause = 1'b0; x = 1'b0;

        // Reset low for two cycles with a load pending.
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("rst_bcd_out",  32'(bcd_out),  32'h0000);
        chk("rst_busy",     32'(busy),     32'h0);
        chk("rst_done",     32'(done),     32'h0);
        chk("rst_load_err", 32'(load_err), 32'h0);

        // Load 0102, start, count down to zero.
        drive(1'b1, 1'b1, 16'h0102, 1'b0, 1'b0, 1'b0);
        chk("ld_bcd_out", 32'(bcd_out), 32'h0102);
        chk("ld_busy",    32'(busy),    32'h0);
        drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        chk("start_busy",    32'(busy),    32'h1);
        chk("start_bcd_out", 32'(bcd_out), 32'h0102);
        for (int i = 1; i <= 102; i++) begin
            drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
            if (i == 1)   chk("cd_0101", 32'(bcd_out), 32'h0101);
            if (i == 2)   chk("cd_0100", 32'(bcd_out), 32'h0100);
            if (i == 3)   chk("cd_0099", 32'(bcd_out), 32'h0099);
            if (i == 4)   chk("cd_0098", 32'(bcd_out), 32'h0098);
            if (i == 101) chk("cd_0001", 32'(bcd_out), 32'h0001);
            if (i == 102) chk("cd_0000", 32'(bcd_out), 32'h0000);
            chk("cd_done", 32'(done), (i == 102) ? 32'h1 : 32'h0);
        end
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("cd_after_busy", 32'(busy), 32'h0);
        chk("cd_after_done", 32'(done), 32'h0);
        chk("cd_after_bcd",  32'(bcd_out), 32'h0000);

        // Multi-digit borrow, then a rejected load.
        drive(1'b1, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("borrow_0999", 32'(bcd_out), 32'h0999);
        drive(1'b1, 1'b1, 16'h0A00, 1'b0, 1'b0, 1'b1);
        chk("bad_ld_err", 32'(load_err), 32'h1);
        chk("bad_ld_bcd", 32'(bcd_out),  32'h0999);
        chk("bad_ld_busy", 32'(busy),    32'h1);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("bad_ld_cont", 32'(bcd_out),  32'h0998);
        chk("err_held",    32'(load_err), 32'h1);

        // Pause at 0050 with start and x also high, hold, then resume.
        drive(1'b1, 1'b1, 16'h0052, 1'b0, 1'b0, 1'b0);
        chk("good_ld_err", 32'(load_err), 32'h0);
        drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("pre_pause", 32'(bcd_out), 32'h0050);
        drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        chk("pause_bcd",  32'(bcd_out), 32'h0050);
        chk("pause_busy", 32'(busy),    32'h1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
            chk("paused_hold", 32'(bcd_out), 32'h0050);
        end
        drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        chk("resume_bcd", 32'(bcd_out), 32'h0050);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("resume_dec", 32'(bcd_out), 32'h0049);

        // Load wins over a terminal decrement.
        drive(1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("at1_busy", 32'(busy), 32'h1);
        drive(1'b1, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b1);
        chk("ldwin_bcd",  32'(bcd_out), 32'h0007);
        chk("ldwin_busy", 32'(busy),    32'h0);
        chk("ldwin_done", 32'(done),    32'h0);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("ldwin_done2", 32'(done), 32'h0);
        chk("idle_x_ign",  32'(bcd_out), 32'h0007);

        // Start with a zero count stays idle.
        drive(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        chk("zero_start_busy", 32'(busy), 32'h0);
        chk("zero_start_done", 32'(done), 32'h0);

        // Reset mid-RUN at 0123.
        drive(1'b1, 1'b1, 16'h0125, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("pre_rst_bcd", 32'(bcd_out), 32'h0123);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        chk("midrst_bcd",  32'(bcd_out), 32'h0000);
        chk("midrst_busy", 32'(busy),    32'h0);
        chk("midrst_done", 32'(done),    32'h0);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("postrst_done", 32'(done), 32'h0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
